quarter_sin_nco: RTL and testbench
==================================

QUARTER_SIN_NCO -- requirements
Module: quarter_sin_nco

Interface
REQ-001 Parameter PHASE_W, default 10, phase width in bits; one full sine period spans 2^PHASE_W codes; minimum 4.
REQ-002 Parameter DATA_W, default 12, width of the signed two's-complement output samples.
REQ-003 Port clk, input, 1, single clock; all logic on the rising edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1, qualifies phase_in for the current cycle.
REQ-006 Port phase_in, input, PHASE_W, absolute phase (mode=0) or phase increment (mode=1).
REQ-007 Port mode, input, 1, 0 = direct phase lookup, 1 = NCO accumulator.
REQ-008 Port phase_clr, input, 1, synchronous clear of the accumulator.
REQ-009 Port amp_shift, input, 2, arithmetic right-shift of the output amplitude, 0..3.
REQ-010 Port out_valid, output, 1, sample valid strobe.
REQ-011 Port sin_out, output, DATA_W, signed sine sample.
REQ-012 Port cos_out, output, DATA_W, signed cosine sample; present only with SIN_LUT_COS_EN.

Function
REQ-013 The ROM SHALL hold 2^(PHASE_W-2) quarter-wave entries: ROM[k] = round((2^(DATA_W-1)-1)*sin(2*pi*(k+0.5)/2^PHASE_W)).
REQ-014 The effective phase SHALL be:
- mode=0: phase_in.
- mode=1: the accumulator value before this cycle's add.
REQ-015 In mode=1 with in_valid=1, the accumulator SHALL add phase_in modulo 2^PHASE_W.
REQ-016 The accumulator SHALL hold its value when in_valid=0 or mode=0.
REQ-017 When phase_clr=1, the accumulator SHALL load 0 and the effective phase SHALL be 0; phase_clr has priority over the add.
REQ-018 Quadrant and index SHALL be derived from the effective phase:
- quadrant = the top 2 bits; idx = the low PHASE_W-2 bits.
- Quadrants 1 and 3 SHALL use the mirrored index ~idx.
- Quadrants 2 and 3 SHALL negate the ROM value.
REQ-019 The cosine SHALL use the effective phase + 2^(PHASE_W-2), mod 2^PHASE_W, through the same rules.
REQ-020 The pipeline SHALL have three registered stages:
- S1: quadrant, index, sign, amp_shift.
- S2: ROM read.
- S3: negate, then arithmetic shift.
REQ-021 out_valid SHALL equal in_valid delayed by exactly 3 cycles, with no bubbles and full throughput.
REQ-022 When out_valid=0, sin_out and cos_out SHALL hold their last values.
REQ-023 No output SHALL overflow: |ROM| ≤ 2^(DATA_W-1)-1, so negation is always exact.

Reset
REQ-024 Assertion of rst_n SHALL immediately clear the accumulator, all pipeline valids, sin_out, cos_out and out_valid to 0.
REQ-025 A reset mid-stream SHALL discard every in-flight sample; the first out_valid SHALL come 3 cycles after the first post-reset in_valid.

Configuration
REQ-026 With SIN_LUT_COS_EN defined, the cos_out port SHALL exist and a second ROM read port SHALL be instantiated.
REQ-027 Without SIN_LUT_COS_EN, cos_out and its logic SHALL be absent; sin_out timing SHALL be unchanged.

Structure
REQ-028 The shared package sin_lut_pkg SHALL hold:
- the quadrant enum (Q0..Q3);
- the default PHASE_W and DATA_W constants;
- the ROM-init function computing REQ-013.
REQ-029 The ROM SHALL be the sub-module sin_qtr_rom: registered read, one or two ports, depth 2^(PHASE_W-2).

Verification (PHASE_W=10, DATA_W=12)
REQ-030 mode=0, amp_shift=0, phases 0, 256, 512, 768 on consecutive cycles -> sin_out 6, 2047, -6, -2047 at cycles 3..6; cos_out 2047, -6, -2047, 6.
REQ-031 mode=1, increment 256, phase_clr pulsed in the first cycle, 4 valid cycles -> sin_out 6, 2047, -6, -2047; accumulator ends at 0 (wrap).
REQ-032 Phase 768 with amp_shift=1 -> sin_out -1024; with amp_shift=3 -> -256.
REQ-033 in_valid pattern 1,0,1,1 -> out_valid 1,0,1,1 delayed by 3 cycles; outputs hold during the gap.
REQ-034 rst_n asserted with 2 samples in flight -> out_valid never rises for them; all outputs read 0 during reset.
REQ-035 mode=1 with phase_clr and in_valid in the same cycle, increment 100 -> that sample uses phase 0 (sin_out 6); the next sample uses phase 0, not 100.

Source files
------------

// File: rtl/sin_lut_pkg.sv
// rtl/sin_lut_pkg.sv - shared types, default widths and quarter-wave ROM contents
// Integer Taylor series so the table folds to constants without real arithmetic.
package sin_lut_pkg;

  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} quad_e;

  localparam int PHASE_W_DEF = 10;
  localparam int DATA_W_DEF  = 12;

  localparam int     FRAC_W = 30;
  localparam longint PI_FX  = 64'sd3373259426;

  // round((2^(data_w-1)-1) * sin(pi*(2k+1)/2^phase_w)); the angle stays below pi/2
  function automatic longint rom_entry(input int k, input int phase_w, input int data_w);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (PI_FX * longint'(2 * k + 1)) >>> phase_w;
    x2   = (x * x) >>> FRAC_W;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -((term * x2) >>> FRAC_W) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = (longint'(1) <<< (data_w - 1)) - 1;
    return (amp * sum + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
  endfunction

endpackage

// File: rtl/sin_qtr_rom.sv
// rtl/sin_qtr_rom.sv - quarter-wave sine ROM with registered read
// Second read port exists only when SIN_LUT_COS_EN is defined.
module sin_qtr_rom
  import sin_lut_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic [PHASE_W-3:0]       i_addr_a,
  output logic signed [DATA_W-1:0] o_data_a
`ifdef SIN_LUT_COS_EN
  ,
  input  logic [PHASE_W-3:0]       i_addr_b,
  output logic signed [DATA_W-1:0] o_data_b
`endif
);

  localparam int DEPTH = 2 ** (PHASE_W - 2);

  logic signed [DATA_W-1:0] w_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign w_rom[k] = DATA_W'(rom_entry(k, PHASE_W, DATA_W));
  end

  always_ff @(posedge clk) begin
    o_data_a <= w_rom[i_addr_a];
  end

`ifdef SIN_LUT_COS_EN
  always_ff @(posedge clk) begin
    o_data_b <= w_rom[i_addr_b];
  end
`endif

endmodule

// File: rtl/quarter_sin_nco.sv
// rtl/quarter_sin_nco.sv - 3-stage quarter-wave sine lookup / NCO
// Cosine output and second ROM port present only with SIN_LUT_COS_EN.
module quarter_sin_nco
  import sin_lut_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [PHASE_W-1:0]       phase_in,
  input  logic                     mode,
  input  logic                     phase_clr,
  input  logic [1:0]               amp_shift,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] sin_out
`ifdef SIN_LUT_COS_EN
  ,
  output logic signed [DATA_W-1:0] cos_out
`endif
);

  localparam int                 IDX_W     = PHASE_W - 2;
  localparam logic [PHASE_W-1:0] QTR_PHASE = PHASE_W'(1) << IDX_W;

  function automatic logic [IDX_W-1:0] rom_idx(input logic [PHASE_W-1:0] ph);
    quad_e q;
    q = quad_e'(ph[PHASE_W-1 -: 2]);
    return (q == Q1 || q == Q3) ? ~ph[IDX_W-1:0] : ph[IDX_W-1:0];
  endfunction

  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] w_phase;

  // The sample taken in an accumulating cycle uses the pre-add value
  always_comb begin
    w_phase = phase_in;
    if (phase_clr)
      w_phase = '0;
    else if (mode)
      w_phase = r_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_acc <= '0;
    else if (phase_clr)
      r_acc <= '0;
    else if (in_valid && mode)
      r_acc <= r_acc + phase_in;
  end

  logic             r_s1_valid;
  logic [IDX_W-1:0] r_s1_sin_idx;
  logic             r_s1_sin_neg;
  logic [1:0]       r_s1_shift;
  logic             r_s2_valid;
  logic             r_s2_sin_neg;
  logic [1:0]       r_s2_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sin_idx <= '0;
      r_s1_sin_neg <= 1'b0;
      r_s1_shift   <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_sin_neg <= 1'b0;
      r_s2_shift   <= '0;
    end else begin
      r_s1_valid   <= in_valid;
      r_s1_sin_idx <= rom_idx(w_phase);
      r_s1_sin_neg <= w_phase[PHASE_W-1];
      r_s1_shift   <= amp_shift;
      r_s2_valid   <= r_s1_valid;
      r_s2_sin_neg <= r_s1_sin_neg;
      r_s2_shift   <= r_s1_shift;
    end
  end

  logic signed [DATA_W-1:0] w_rom_sin;
  logic signed [DATA_W-1:0] w_sin_signed;

`ifdef SIN_LUT_COS_EN
  logic [PHASE_W-1:0]       w_cos_phase;
  logic [IDX_W-1:0]         r_s1_cos_idx;
  logic                     r_s1_cos_neg;
  logic                     r_s2_cos_neg;
  logic signed [DATA_W-1:0] w_rom_cos;
  logic signed [DATA_W-1:0] w_cos_signed;

  assign w_cos_phase = w_phase + QTR_PHASE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_cos_idx <= '0;
      r_s1_cos_neg <= 1'b0;
      r_s2_cos_neg <= 1'b0;
    end else begin
      r_s1_cos_idx <= rom_idx(w_cos_phase);
      r_s1_cos_neg <= w_cos_phase[PHASE_W-1];
      r_s2_cos_neg <= r_s1_cos_neg;
    end
  end

  sin_qtr_rom #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) u_rom (
    .clk      (clk),
    .i_addr_a (r_s1_sin_idx),
    .o_data_a (w_rom_sin),
    .i_addr_b (r_s1_cos_idx),
    .o_data_b (w_rom_cos)
  );

  assign w_cos_signed = r_s2_cos_neg ? -w_rom_cos : w_rom_cos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cos_out <= '0;
    else if (r_s2_valid)
      cos_out <= w_cos_signed >>> r_s2_shift;
  end
`else
  sin_qtr_rom #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) u_rom (
    .clk      (clk),
    .i_addr_a (r_s1_sin_idx),
    .o_data_a (w_rom_sin)
  );
`endif

  // ROM magnitude never exceeds 2^(DATA_W-1)-1, so negation cannot overflow
  assign w_sin_signed = r_s2_sin_neg ? -w_rom_sin : w_rom_sin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sin_out   <= '0;
    end else begin
      out_valid <= r_s2_valid;
      if (r_s2_valid)
        sin_out <= w_sin_signed >>> r_s2_shift;
    end
  end

endmodule

// File: tb/tb_quarter_sin_nco.sv
// tb/tb_quarter_sin_nco.sv - scoreboard bench for quarter_sin_nco against a real-valued sine model
// Cosine checks compile in only with SIN_LUT_COS_EN.
module tb_quarter_sin_nco;

  localparam int  PW   = 10;
  localparam int  DW   = 12;
  localparam int  N    = 1 << PW;
  localparam int  AMP  = (1 << (DW - 1)) - 1;
  localparam real PI_R = 3.14159265358979323846;

  typedef struct {
    int cyc;
    int sin_v;
    int cos_v;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [PW-1:0]        phase_in = '0;
  logic                 mode = 1'b0;
  logic                 phase_clr = 1'b0;
  logic [1:0]           amp_shift = '0;
  logic                 out_valid;
  logic signed [DW-1:0] sin_out;
`ifdef SIN_LUT_COS_EN
  logic signed [DW-1:0] cos_out;
`endif

  quarter_sin_nco #(.PHASE_W(PW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .phase_in  (phase_in),
    .mode      (mode),
    .phase_clr (phase_clr),
    .amp_shift (amp_shift),
    .out_valid (out_valid),
    .sin_out   (sin_out)
`ifdef SIN_LUT_COS_EN
    ,
    .cos_out   (cos_out)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_acc = 0;
  int   last_sin = 0;
  int   last_cos = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Sample of an ideal sine/cosine at the centre of the phase bin, magnitude rounded
  function automatic int ref_wave(input int p, input bit is_cos, input int sh);
    real ang;
    real v;
    real mag;
    int  r;
    ang = 2.0 * PI_R * (real'(p) + 0.5) / real'(N);
    v   = is_cos ? $cos(ang) : $sin(ang);
    mag = ((v < 0.0) ? -v : v) * real'(AMP);
    r   = $rtoi(mag + 0.5);
    if (v < 0.0) r = -r;
    return r >>> sh;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic send(input bit v, input int ph, input bit md, input bit clr, input int sh);
    int   eff;
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    phase_in  = ph[PW-1:0];
    mode      = md;
    phase_clr = clr;
    amp_shift = sh[1:0];
    eff = clr ? 0 : (md ? model_acc : (ph % N));
    if (clr)
      model_acc = 0;
    else if (v && md)
      model_acc = (model_acc + ph) % N;
    if (v) begin
      e.cyc   = cyc + 3;
      e.sin_v = ref_wave(eff, 1'b0, sh);
      e.cos_v = ref_wave(eff, 1'b1, sh);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      idle(1);
      budget++;
    end
    idle(2);
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: compare at mid-cycle, after the driver has updated the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        last_sin = 0;
        last_cos = 0;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_sin_out", int'(sin_out), 0);
`ifdef SIN_LUT_COS_EN
        check("reset_cos_out", int'(cos_out), 0);
`endif
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("latency_cycle", cyc, e.cyc);
          check("sin_out", int'(sin_out), e.sin_v);
          last_sin = e.sin_v;
`ifdef SIN_LUT_COS_EN
          check("cos_out", int'(cos_out), e.cos_v);
          last_cos = e.cos_v;
`endif
        end
      end else begin
        check("hold_sin_out", int'(sin_out), last_sin);
`ifdef SIN_LUT_COS_EN
        check("hold_cos_out", int'(cos_out), last_cos);
`endif
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Four quadrant boundaries, direct lookup
    send(1, 0, 0, 0, 0);
    send(1, 256, 0, 0, 0);
    send(1, 512, 0, 0, 0);
    send(1, 768, 0, 0, 0);
    drain();

    // Accumulator from a clear, four increments of 256, wraps to 0
    send(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) send(1, 256, 1, 0, 0);
    drain();
    check("acc_wrap_model", model_acc, 0);
    send(1, 5, 1, 0, 0);
    drain();

    // Amplitude shifts on a negative peak
    send(1, 768, 0, 0, 1);
    send(1, 768, 0, 0, 3);
    send(1, 100, 0, 0, 2);
    drain();

    // Gap in the valid stream; outputs hold through it
    send(1, 300, 0, 0, 0);
    send(0, 600, 0, 0, 0);
    send(1, 900, 0, 0, 0);
    send(1, 50, 0, 0, 0);
    drain();

    // Clear and valid together: clear wins, next sample also sees phase 0
    send(1, 700, 1, 0, 0);
    send(1, 100, 1, 1, 0);
    send(1, 100, 1, 0, 0);
    send(1, 100, 1, 0, 0);
    drain();

    // Reset with two samples in flight
    send(1, 200, 0, 0, 0);
    send(1, 400, 0, 0, 0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    model_acc = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    send(1, 128, 1, 0, 0);
    send(1, 64, 1, 0, 0);
    drain();

    // Randomised mix of modes, clears, shifts and gaps
    for (int i = 0; i < 400; i++) begin
      send(($urandom % 4) != 0, int'($urandom % N), $urandom % 2, ($urandom % 10) == 0,
           int'($urandom % 4));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
